lv_wdg_tmo_chk: RTL and testbench

// - Watchdog timeout checker for the LV die. It consumes o_wdg_scan_en and o_wdg_owt_en from the LV control FSM.
// - It produces the FSM's i_wdg_tmo_err input.
// - Two independent channels: SCAN expects periodic scan-done kicks; OWT expects periodic valid one-wire frames.
// - A channel missing its kick window raises a sticky timeout flag. The flag holds until the FSM/regs clear it.

---
 rtl/lv_wdg_tmo_chk.sv | 102 ++++++++++
 tb/tb_lv_wdg_tmo_chk.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lv_wdg_tmo_chk.sv
// rtl/lv_wdg_tmo_chk.sv - LV die watchdog timeout checker (SCAN and OWT channels)
module lv_wdg_tmo_chk #(
  parameter int TICK_DIV = 100,
  parameter int CNT_W    = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wdg_scan_en,
  input  logic             i_wdg_owt_en,
  input  logic             i_scan_kick,
  input  logic             i_owt_kick,
  input  logic [CNT_W-1:0] i_scan_tmo_th,
  input  logic [CNT_W-1:0] i_owt_tmo_th,
  input  logic             i_err_clr,
  output logic             o_scan_tmo,
  output logic             o_owt_tmo,
  output logic             o_wdg_tmo_err
);

  localparam int               PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_TMO  = 2'd2
  } wdg_st_e;

  logic [PRE_W-1:0]      pre_q, pre_d;
  logic                  tick;
  logic [1:0]            en, kick, tmo_q, tmo_d;
  logic [1:0][CNT_W-1:0] th, cnt_q, cnt_d;
  logic [1:0][CNT_W:0]   cnt_inc;
  wdg_st_e               st_q [2];
  wdg_st_e               st_d [2];

  // Channel 0 is SCAN, channel 1 is OWT.
  assign en   = {i_wdg_owt_en, i_wdg_scan_en};
  assign kick = {i_owt_kick, i_scan_kick};
  assign th   = {i_owt_tmo_th, i_scan_tmo_th};

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = (|en) ? (tick ? '0 : pre_q + PRE_W'(1)) : '0;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      cnt_inc[c] = {1'b0, cnt_q[c]} + {{CNT_W{1'b0}}, 1'b1};
      st_d[c]    = st_q[c];
      cnt_d[c]   = cnt_q[c];
      case (st_q[c])
        ST_IDLE: begin
          cnt_d[c] = '0;
          if (en[c]) st_d[c] = ST_ARM;
        end
        ST_ARM: begin
          if (!en[c]) begin
            st_d[c]  = ST_IDLE;
            cnt_d[c] = '0;
          end else if (kick[c] || (th[c] == '0)) begin
            cnt_d[c] = '0;
          end else if (tick) begin
            // Live compare: a threshold lowered below cnt trips on this tick.
            if (cnt_inc[c] >= {1'b0, th[c]}) st_d[c] = ST_TMO;
            else if (!(&cnt_q[c])) cnt_d[c] = cnt_inc[c][CNT_W-1:0];
          end
        end
        ST_TMO: begin
          if (i_err_clr) begin
            cnt_d[c] = '0;
            st_d[c]  = en[c] ? ST_ARM : ST_IDLE;
          end
        end
        default: begin
          st_d[c]  = ST_IDLE;
          cnt_d[c] = '0;
        end
      endcase
      tmo_d[c] = (st_d[c] == ST_TMO);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      st_q[0] <= ST_IDLE;
      st_q[1] <= ST_IDLE;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
    end
  end

  assign o_scan_tmo    = tmo_q[0];
  assign o_owt_tmo     = tmo_q[1];
  assign o_wdg_tmo_err = tmo_q[0] | tmo_q[1];

endmodule

// File: tb/tb_lv_wdg_tmo_chk.sv
// tb/tb_lv_wdg_tmo_chk.sv - self-checking bench for lv_wdg_tmo_chk
module tb_lv_wdg_tmo_chk;
  localparam int TD = 4;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          scan_en = 1'b0, owt_en = 1'b0;
  logic          scan_kick = 1'b0, owt_kick = 1'b0, err_clr = 1'b0;
  logic [CW-1:0] scan_th = '0, owt_th = '0;
  logic          scan_tmo, owt_tmo, tmo_err;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  int lat;

  // Reference model: tick phase, per-channel armed/timed-out, ticks since kick.
  int m_pre;
  bit m_arm [2];
  bit m_tmo [2];
  int m_n   [2];
  bit m_tick;
  bit m_en  [2];
  bit m_kk  [2];
  int m_th  [2];

  always #5 clk = ~clk;

  lv_wdg_tmo_chk #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_wdg_scan_en (scan_en),
    .i_wdg_owt_en  (owt_en),
    .i_scan_kick   (scan_kick),
    .i_owt_kick    (owt_kick),
    .i_scan_tmo_th (scan_th),
    .i_owt_tmo_th  (owt_th),
    .i_err_clr     (err_clr),
    .o_scan_tmo    (scan_tmo),
    .o_owt_tmo     (owt_tmo),
    .o_wdg_tmo_err (tmo_err)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre = 0;
      for (int c = 0; c < 2; c++) begin
        m_arm[c] = 1'b0;
        m_tmo[c] = 1'b0;
        m_n[c]   = 0;
      end
    end else begin
      m_tick = (m_pre == TD - 1);
      m_en[0] = scan_en;   m_en[1] = owt_en;
      m_kk[0] = scan_kick; m_kk[1] = owt_kick;
      m_th[0] = int'(scan_th); m_th[1] = int'(owt_th);
      m_pre = (scan_en || owt_en) ? (m_pre + 1) % TD : 0;
      for (int c = 0; c < 2; c++) begin
        if (m_tmo[c]) begin
          if (err_clr) begin
            m_tmo[c] = 1'b0;
            m_arm[c] = m_en[c];
            m_n[c]   = 0;
          end
        end else if (!m_arm[c]) begin
          m_arm[c] = m_en[c];
          m_n[c]   = 0;
        end else if (!m_en[c]) begin
          m_arm[c] = 1'b0;
          m_n[c]   = 0;
        end else if (m_kk[c] || m_th[c] == 0) begin
          m_n[c] = 0;
        end else if (m_tick) begin
          if (m_n[c] + 1 >= m_th[c]) m_tmo[c] = 1'b1;
          else m_n[c] = m_n[c] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("cyc_scan_tmo", int'(scan_tmo), int'(m_tmo[0]));
      chk("cyc_owt_tmo", int'(owt_tmo), int'(m_tmo[1]));
      chk("cyc_tmo_err", int'(tmo_err), int'(m_tmo[0] | m_tmo[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    scan_en = 1'b0; owt_en = 1'b0; scan_kick = 1'b0; owt_kick = 1'b0;
    err_clr = 1'b0; scan_th = '0; owt_th = '0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic wait_flag(input int ch, input int maxc, output int l);
    l = -1;
    for (int k = 1; k <= maxc; k++) begin
      cyc(1);
      if ((ch == 0) ? scan_tmo : owt_tmo) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int found;
    cyc(2);
    chk("reset_scan", int'(scan_tmo), 0);
    chk("reset_owt", int'(owt_tmo), 0);
    chk("reset_err", int'(tmo_err), 0);
    rst_n = 1'b1;
    cyc(1);
    cmp_en = 1'b1;

    // Scan timeout from a fresh prescaler.
    scan_th = 3; scan_en = 1'b1;
    wait_flag(0, 20, lat);
    chk_rng("scan_lat", lat, 9, 12);
    chk("scan_lat_exact", lat, 12);
    chk("scan_err_or", int'(tmo_err), 1);
    chk("scan_owt_quiet", int'(owt_tmo), 0);

    // Kicks every 8 cycles keep the channel alive.
    do_reset();
    scan_th = 3; scan_en = 1'b1;
    repeat (25) begin
      cyc(7);
      scan_kick = 1'b1;
      cyc(1);
      scan_kick = 1'b0;
    end
    chk("kick_alive", int'(scan_tmo), 0);
    wait_flag(0, 20, lat);
    chk_rng("kick_stop_lat", lat, 9, 12);

    // Flag is sticky with en=0 until cleared.
    scan_en = 1'b0;
    cyc(5);
    chk("clr_sticky", int'(scan_tmo), 1);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    chk("clr_idle", int'(scan_tmo), 0);
    cyc(3);
    chk("clr_idle_hold", int'(scan_tmo), 0);
    scan_en = 1'b1;
    wait_flag(0, 20, lat);
    chk_rng("rearm_lat", lat, 9, 12);
    cyc(3);
    err_clr = 1'b1; cyc(1); err_clr = 1'b0;
    chk("clr_en1", int'(scan_tmo), 0);
    wait_flag(0, 20, lat);
    chk_rng("clr_en1_lat", lat, 9, 12);

    // OWT with threshold 0 never times out.
    do_reset();
    owt_en = 1'b1; owt_th = 0;
    cyc(500);
    chk("owt_th0", int'(owt_tmo), 0);
    owt_th = 2;
    wait_flag(1, 8, lat);
    chk_rng("owt_th2_lat", lat, 1, 8);
    chk("owt_scan_quiet", int'(scan_tmo), 0);

    // Kick on the threshold tick wins; window restarts from zero.
    do_reset();
    scan_th = 3; scan_en = 1'b1;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (m_n[0] == 2 && m_pre == TD - 1) begin
        found = 1;
        break;
      end
      cyc(1);
    end
    chk("prio_align", found, 1);
    scan_kick = 1'b1; cyc(1); scan_kick = 1'b0;
    chk("prio_no_tmo", int'(scan_tmo), 0);
    chk("prio_model_cnt", m_n[0], 0);
    wait_flag(0, 20, lat);
    chk("prio_lat", lat, 12);

    // Disable mid-count then re-enable restarts the full window.
    do_reset();
    scan_th = 3; scan_en = 1'b1;
    cyc(10);
    scan_en = 1'b0;
    cyc(2);
    scan_en = 1'b1;
    wait_flag(0, 20, lat);
    chk("reen_lat", lat, 12);

    // Asynchronous reset with both flags set.
    do_reset();
    scan_th = 1; owt_th = 1; scan_en = 1'b1; owt_en = 1'b1;
    cyc(6);
    chk("rst_pre_scan", int'(scan_tmo), 1);
    chk("rst_pre_owt", int'(owt_tmo), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_scan", int'(scan_tmo), 0);
    chk("rst_async_owt", int'(owt_tmo), 0);
    chk("rst_async_err", int'(tmo_err), 0);
    cyc(2);
    scan_en = 1'b0; owt_en = 1'b0;
    rst_n = 1'b1;
    cyc(3);
    chk("rst_rel_err", int'(tmo_err), 0);
    scan_th = 3; scan_en = 1'b1;
    wait_flag(0, 20, lat);
    chk("rst_rel_lat", lat, 12);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) scan_en = ~scan_en;
      if ($urandom_range(0, 29) == 0) owt_en = ~owt_en;
      if ($urandom_range(0, 49) == 0) scan_th = CW'($urandom_range(0, 4));
      if ($urandom_range(0, 49) == 0) owt_th = CW'($urandom_range(0, 4));
      scan_kick = ($urandom_range(0, 11) == 0);
      owt_kick  = ($urandom_range(0, 11) == 0);
      err_clr   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end else begin
        cyc(1);
      end
    end
    scan_kick = 1'b0; owt_kick = 1'b0; err_clr = 1'b0;
    cyc(2);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
